// File: rtl/rf_write_buffer_pkg.sv
// Shared register-file definitions and write-buffer queue operation encoding.
package rf_write_buffer_pkg;

  localparam int unsigned RF_DW       = 32;
  localparam int unsigned RF_AW       = 5;
  localparam int unsigned RF_NUM_REGS = 32;
  localparam logic [RF_AW-1:0] RF_REG_ZERO = '0;

  // Queue operation requested in a cycle, encoded as {push, pop}
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/rf_write_buffer_fifo.sv
// Pending-write queue: {rd, data} entries, head/tail pointers, occupancy count.
// The whole entry array is exposed flat so the top level can scan it.
module wb_entry_fifo
  import rf_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = RF_DW,
  parameter int unsigned AW    = RF_AW,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [AW-1:0]       push_rd,
  input  logic [DW-1:0]       push_data,
  output logic [AW-1:0]       head_rd,
  output logic [DW-1:0]       head_data,
  output logic [PW-1:0]       head_ptr,
  output logic [CW-1:0]       count,
  output logic [DEPTH*AW-1:0] ent_rd,
  output logic [DEPTH*DW-1:0] ent_data
);

  logic [AW-1:0] rd_mem   [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  fifo_op_e      op;

  assign op = fifo_op(push, pop);

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      case (op)
        FIFO_PUSH: begin
          tail_q  <= tail_q + PW'(1);
          count_q <= count_q + CW'(1);
        end
        FIFO_POP: begin
          head_q  <= head_q + PW'(1);
          count_q <= count_q - CW'(1);
        end
        FIFO_BOTH: begin
          tail_q <= tail_q + PW'(1);
          head_q <= head_q + PW'(1);
        end
        default: ;
      endcase
    end
  end

  // Entry storage; contents are don't-care after reset so no reset is applied
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail_q]   <= push_rd;
      data_mem[tail_q] <= push_data;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign ent_rd[i*AW +: AW]   = rd_mem[i];
    assign ent_data[i*DW +: DW] = data_mem[i];
  end

  assign head_rd   = rd_mem[head_q];
  assign head_data = data_mem[head_q];
  assign head_ptr  = head_q;
  assign count     = count_q;

endmodule

// File: rtl/rf_write_buffer.sv
// Writeback buffer in front of the register file write port: queues writes,
// drains one per cycle, and forwards pending values onto both read ports.
module rf_write_buffer
  import rf_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = RF_DW,
  parameter int unsigned AW    = RF_AW,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rd,
  input  logic [DW-1:0] in_data,
  input  logic          drain_en,
  output logic          rf_write,
  output logic [AW-1:0] rf_rd,
  output logic [DW-1:0] rf_data,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic [DW-1:0] rf_out0,
  input  logic [DW-1:0] rf_out1,
  output logic [DW-1:0] data_out0,
  output logic [DW-1:0] data_out1,
  output logic [CW-1:0] count
);

  logic                push;
  logic                pop;
  logic [PW-1:0]       head_ptr;
  logic [DEPTH*AW-1:0] ent_rd;
  logic [DEPTH*DW-1:0] ent_data;
  logic [DEPTH-1:0]    match0;
  logic [DEPTH-1:0]    match1;
  logic [DW-1:0]       age_data [DEPTH];

  // in_ready depends only on registered count, so a same-cycle pop never raises it
  assign in_ready = (count < CW'(DEPTH));
  // Writes to r0 complete the handshake but are dropped
  assign push     = in_valid & in_ready & (in_rd != AW'(RF_REG_ZERO));
  assign pop      = drain_en & (count != '0);
  assign rf_write = pop;

  wb_entry_fifo #(
    .DEPTH(DEPTH),
    .DW   (DW),
    .AW   (AW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .push_rd  (in_rd),
    .push_data(in_data),
    .head_rd  (rf_rd),
    .head_data(rf_data),
    .head_ptr (head_ptr),
    .count    (count),
    .ent_rd   (ent_rd),
    .ent_data (ent_data)
  );

  // Slot i holds the i-th oldest entry counted from head; higher i is younger
  for (genvar i = 0; i < DEPTH; i++) begin : g_scan
    logic [PW-1:0] idx;
    logic          live;
    logic [AW-1:0] e_rd;

    assign idx         = head_ptr + PW'(i);
    assign live        = (CW'(i) < count);
    assign e_rd        = ent_rd[idx*AW +: AW];
    assign age_data[i] = ent_data[idx*DW +: DW];
    assign match0[i]   = live & (e_rd == rs);
    assign match1[i]   = live & (e_rd == rt);
  end

  // Youngest matching pending entry overrides the register file; r0 always reads zero
  always_comb begin
    data_out0 = rf_out0;
    data_out1 = rf_out1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (match0[i]) data_out0 = age_data[i];
      if (match1[i]) data_out1 = age_data[i];
    end
    if (rs == AW'(RF_REG_ZERO)) data_out0 = '0;
    if (rt == AW'(RF_REG_ZERO)) data_out1 = '0;
  end

endmodule
